// File: rtl/x25519_apb_sequencer.sv
// APB requester that runs one X25519 scalar multiplication on the accelerator.
// It loads the scalar and u-coordinate, starts the operation, polls for completion and reads back the result.
module x25519_apb_sequencer #(
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned POLL_DELAY = 4,
    parameter int unsigned MAX_POLLS  = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [255:0]          in_e,
    input  logic [255:0]          in_u,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [255:0]          out_data,
    output logic                  out_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [31:0]           pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [31:0]           prdata
);

    typedef enum logic [2:0] {
        IDLE, WR_E, WR_WORK, WR_CMD, DELAY, POLL, RD_OUT, DONE
    } state_t;

    localparam int unsigned OFF_E      = 32'h000;
    localparam int unsigned OFF_STATUS = 32'h020;
    localparam int unsigned OFF_CMD    = 32'h028;
    localparam int unsigned OFF_WORK   = 32'h060;
    localparam int unsigned OFF_OUT    = 32'h140;

    state_t       state;
    logic [255:0] e_buf;
    logic [255:0] u_buf;
    logic [2:0]   idx;
    logic [7:0]   delay_cnt;
    logic [15:0]  poll_cnt;

    logic [2:0]   next_idx;
    logic [7:0]   next_sel;
    logic [15:0]  poll_next;

    assign next_idx  = idx + 3'd1;
    assign next_sel  = {next_idx, 5'd0};
    assign poll_next = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

    function automatic logic [ADDR_WIDTH-1:0] reg_addr(input int unsigned off, input logic [2:0] word);
        int unsigned word_off;
        word_off = 32'(word) << 2;
        return ADDR_WIDTH'(BASE_ADDR + off + word_off);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            e_buf     <= '0;
            u_buf     <= '0;
            idx       <= '0;
            delay_cnt <= '0;
            poll_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        e_buf    <= in_e;
                        u_buf    <= in_u;
                        idx      <= '0;
                        poll_cnt <= '0;
                        out_err  <= 1'b0;
                        out_data <= '0;
                        in_ready <= 1'b0;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        pwrite   <= 1'b1;
                        paddr    <= reg_addr(OFF_E, 3'd0);
                        pwdata   <= in_e[31:0];
                        state    <= WR_E;
                    end
                end

                DELAY: begin
                    if (delay_cnt == 8'(POLL_DELAY - 1)) begin
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        pwrite   <= 1'b0;
                        paddr    <= reg_addr(OFF_STATUS, 3'd0);
                        poll_cnt <= '0;
                        state    <= POLL;
                    end else begin
                        delay_cnt <= delay_cnt + 8'd1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        out_data  <= '0;
                        e_buf     <= '0;
                        u_buf     <= '0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                // Transfer states: setup -> access (wait on pready) -> next setup in the completion cycle.
                default: begin
                    if (!penable) begin
                        penable <= 1'b1;
                    end else if (pready) begin
                        penable <= 1'b0;
                        if (pslverr) begin
                            psel      <= 1'b0;
                            out_err   <= 1'b1;
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            case (state)
                                WR_E: begin
                                    if (idx == 3'd7) begin
                                        idx    <= '0;
                                        paddr  <= reg_addr(OFF_WORK, 3'd0);
                                        pwdata <= u_buf[31:0];
                                        state  <= WR_WORK;
                                    end else begin
                                        idx    <= next_idx;
                                        paddr  <= reg_addr(OFF_E, next_idx);
                                        pwdata <= e_buf[next_sel +: 32];
                                    end
                                end
                                WR_WORK: begin
                                    if (idx == 3'd7) begin
                                        idx    <= '0;
                                        paddr  <= reg_addr(OFF_CMD, 3'd0);
                                        pwdata <= 32'h0000_0001;
                                        state  <= WR_CMD;
                                    end else begin
                                        idx    <= next_idx;
                                        paddr  <= reg_addr(OFF_WORK, next_idx);
                                        pwdata <= u_buf[next_sel +: 32];
                                    end
                                end
                                WR_CMD: begin
                                    psel      <= 1'b0;
                                    delay_cnt <= '0;
                                    state     <= DELAY;
                                end
                                POLL: begin
                                    poll_cnt <= poll_next;
                                    if (!prdata[0]) begin
                                        idx   <= '0;
                                        paddr <= reg_addr(OFF_OUT, 3'd0);
                                        state <= RD_OUT;
                                    end else if (poll_next >= 16'(MAX_POLLS)) begin
                                        psel      <= 1'b0;
                                        out_err   <= 1'b1;
                                        out_data  <= '0;
                                        out_valid <= 1'b1;
                                        state     <= DONE;
                                    end
                                end
                                RD_OUT: begin
                                    out_data[{idx, 5'd0} +: 32] <= prdata;
                                    if (idx == 3'd7) begin
                                        psel      <= 1'b0;
                                        out_valid <= 1'b1;
                                        state     <= DONE;
                                    end else begin
                                        idx   <= next_idx;
                                        paddr <= reg_addr(OFF_OUT, next_idx);
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x25519_apb_sequencer.sv
// Scoreboard bench for x25519_apb_sequencer: an APB completer model with configurable wait states, busy polls and error injection.
// Expected transfer lists and results come from a job-level reference model.
module tb_x25519_apb_sequencer;

    localparam int unsigned AW   = 12;
    localparam int unsigned BASE = 32'h800;
    localparam int unsigned PD   = 4;
    localparam int unsigned MAXP = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [255:0]  in_e = '0;
    logic [255:0]  in_u = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [255:0]  out_data;
    logic          out_err;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic [31:0]   prdata = '0;

    always #5 clk = ~clk;

    x25519_apb_sequencer #(
        .BASE_ADDR (BASE),
        .ADDR_WIDTH(AW),
        .POLL_DELAY(PD),
        .MAX_POLLS (MAXP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_e(in_e), .in_u(in_u),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    typedef struct packed { logic w; logic [AW-1:0] a; logic [31:0] d; } xfer_t;
    typedef struct packed { logic err; logic [255:0] data; } res_t;
    xfer_t xfer_exp[$];
    res_t  res_exp[$];

    // Job configuration owned by the stimulus; the completer picks it up when job_id changes.
    int          job_id = 0;
    int          cfg_wait = 0;
    int          cfg_busy = 0;
    bit          cfg_stuck = 1'b0;
    int          cfg_err_at = 0;
    logic [31:0] cfg_res [8];

    int          seen_id = 0;
    int          busy_left = 0;
    int          xfer_num = 0;
    int          wait_cnt = 0;
    int          ridx;
    logic        su_w;
    logic [AW-1:0] su_a;
    logic [31:0] su_d;
    xfer_t       xo;
    res_t        ro;

    always @(negedge clk) begin
        if (job_id != seen_id) begin
            seen_id   = job_id;
            busy_left = cfg_busy;
            xfer_num  = 0;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = $urandom;
        if (rst) begin
            wait_cnt = 0;
        end else if (psel && !penable) begin
            su_w = pwrite; su_a = paddr; su_d = pwdata;
            wait_cnt = 0;
        end else if (psel && penable) begin
            check("apb_hold", {pwrite, paddr, pwrite ? pwdata : 32'h0}, {su_w, su_a, su_w ? su_d : 32'h0});
            if (wait_cnt < cfg_wait) begin
                wait_cnt++;
            end else begin
                pready = 1'b1;
                xfer_num++;
                pslverr = (xfer_num == cfg_err_at);
                if (!pwrite) begin
                    if (paddr == AW'(BASE + 32'h20)) begin
                        prdata[0] = cfg_stuck || (busy_left > 0);
                        if (busy_left > 0) busy_left--;
                    end else if (paddr >= AW'(BASE + 32'h140) && paddr < AW'(BASE + 32'h160)) begin
                        ridx = int'((paddr - AW'(BASE + 32'h140)) >> 2);
                        prdata = cfg_res[ridx];
                    end
                end
                if (xfer_exp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_xfer got addr=%h write=%b expected no transfer", paddr, pwrite);
                end else begin
                    xo = xfer_exp.pop_front();
                    check("xfer_dir", pwrite, xo.w);
                    check("xfer_addr", paddr, xo.a);
                    if (xo.w) check("xfer_wdata", pwdata, xo.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && in_ready) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_valid_overlap got out_valid=1 in_ready=1 expected not both");
            end
            if (out_valid && out_ready) begin
                if (res_exp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result got out_data=%h expected no result", out_data);
                end else begin
                    ro = res_exp.pop_front();
                    check("out_err", out_err, ro.err);
                    check("out_data", out_data, ro.data);
                end
            end
        end
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] le_bytes(input logic [255:0] s);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = s[255 - 8*i -: 8];
        return r;
    endfunction

    // Reference model: whole-job transfer list and outcome, then accept the job.
    task automatic issue_job(input logic [255:0] e, input logic [255:0] u, input logic [255:0] res,
                             input int busy, input bit stuck, input int err_at, input int wt,
                             output res_t r, output int polls);
        xfer_t lst[$];
        bit    tmo;
        bit    err;
        for (int i = 0; i < 8; i++) lst.push_back('{w: 1'b1, a: AW'(BASE + 4*i), d: e[32*i +: 32]});
        for (int i = 0; i < 8; i++) lst.push_back('{w: 1'b1, a: AW'(BASE + 32'h60 + 4*i), d: u[32*i +: 32]});
        lst.push_back('{w: 1'b1, a: AW'(BASE + 32'h28), d: 32'h1});
        tmo   = stuck || (busy >= int'(MAXP));
        polls = tmo ? int'(MAXP) : busy + 1;
        for (int p = 0; p < polls; p++) lst.push_back('{w: 1'b0, a: AW'(BASE + 32'h20), d: 32'h0});
        if (!tmo)
            for (int i = 0; i < 8; i++) lst.push_back('{w: 1'b0, a: AW'(BASE + 32'h140 + 4*i), d: 32'h0});
        err = tmo;
        if (err_at > 0 && err_at <= lst.size()) begin
            while (lst.size() > err_at) void'(lst.pop_back());
            err = 1'b1;
        end
        r.err  = err;
        r.data = err ? '0 : res;
        foreach (lst[k]) xfer_exp.push_back(lst[k]);
        res_exp.push_back(r);

        cfg_wait   = wt;
        cfg_busy   = busy;
        cfg_stuck  = stuck;
        cfg_err_at = err_at;
        for (int i = 0; i < 8; i++) cfg_res[i] = res[32*i +: 32];
        job_id++;

        @(posedge clk); #1;
        check("in_ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_e = e;
        in_u = u;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_e = rand256();
        in_u = rand256();
        check("first_psel", {psel, penable}, 2'b10);
    endtask

    task automatic finish_job(input res_t r, input int polls, input int wt, input int hold);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL out_valid_timeout got no out_valid in %0d cycles expected a result", cyc);
            summary();
        end
        if (wt == 0 && !r.err) check("latency", cyc, 50 + PD + 2*polls);
        check("psel_idle_in_done", psel, 1'b0);
        for (int k = 0; k < hold; k++) begin
            in_valid = k[0];
            in_e = rand256();
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, r.data);
            check("hold_err", out_err, r.err);
            check("hold_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_drop", out_valid, 1'b0);
        check("in_ready_back", in_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("xfers_left", xfer_exp.size(), 0);
        check("results_left", res_exp.size(), 0);
    endtask

    task automatic run_job(input logic [255:0] e, input logic [255:0] u, input logic [255:0] res,
                           input int busy, input bit stuck, input int err_at, input int wt, input int hold);
        res_t r;
        int   polls;
        out_ready = (hold == 0);
        issue_job(e, u, res, busy, stuck, err_at, wt, r, polls);
        finish_job(r, polls, wt, hold);
    endtask

    initial begin
        res_t r;
        int   polls;
        int   cyc;

        repeat (3) @(posedge clk);
        #1;
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_paddr", paddr, '0);
        check("rst_pwdata", pwdata, '0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;

        // RFC 7748 vector 1, zero-wait completer
        run_job(le_bytes(256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4),
                le_bytes(256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c),
                le_bytes(256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552),
                0, 1'b0, 0, 0, 0);
        run_job(rand256(), rand256(), rand256(), 3, 1'b0, 0, 2, 0);
        run_job(rand256(), rand256(), rand256(), 0, 1'b0, 5, 0, 0);
        run_job(rand256(), rand256(), rand256(), 0, 1'b1, 0, 1, 0);
        run_job(rand256(), rand256(), rand256(), 9, 1'b0, 0, 0, 0);
        run_job(rand256(), rand256(), rand256(), 10, 1'b0, 0, 0, 0);
        run_job(rand256(), rand256(), rand256(), 2, 1'b0, 30, 0, 0);
        run_job(rand256(), rand256(), rand256(), 1, 1'b0, 0, 0, 20);

        // Reset during the access phase of WORK word 3
        out_ready = 1'b1;
        issue_job(rand256(), rand256(), rand256(), 0, 1'b0, 0, 2, r, polls);
        cyc = 0;
        while (!(psel && penable && paddr == AW'(BASE + 32'h6C)) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) begin
            vectors++;
            miscompares++;
            $display("FAIL work3_wait got no WORK word 3 access expected one within 500 cycles");
            summary();
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async_psel", {psel, penable}, 2'b00);
        xfer_exp.delete();
        res_exp.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_release_in_ready", in_ready, 1'b1);
        check("rst_release_out_valid", out_valid, 1'b0);
        run_job(rand256(), rand256(), rand256(), 1, 1'b0, 0, 0, 0);

        for (int n = 0; n < 8; n++) begin
            run_job(rand256(), rand256(), rand256(), $urandom_range(0, 4), 1'b0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0,
                    $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? 5 : 0);
        end

        summary();
    end

endmodule
